// File: rtl/sipo_capture.sv
// Serial-in/parallel-out capture cell with a valid/ready holding register.
// Define SIPO_PARITY_EN to append and check one even-parity bit per word.
module sipo_capture #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             CK,
   input  logic             CD,
   input  logic             SI,
   input  logic             SE,
   input  logic             QR,
   output logic [WIDTH-1:0] Q,
   output logic             QV,
   output logic             OVF,
   output logic             PERR
);

`ifdef SIPO_PARITY_EN
   localparam int LAST = WIDTH;
`else
   localparam int LAST = WIDTH - 1;
`endif
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(LAST);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [WIDTH-1:0] shifted, word;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             ovf_q, ovf_d;
   logic             perr_q, perr_d;
   logic             perr_word;
   logic             done, load, drop;

   always_comb begin
      shifted = MSB_FIRST ? {sh_q[WIDTH-2:0], SI}
                          : {SI, sh_q[WIDTH-1:1]};
      done    = SE && (cnt_q == CNT_LAST);
      cnt_d   = cnt_q;
      if (SE) cnt_d = done ? '0 : cnt_q + 1'b1;
`ifdef SIPO_PARITY_EN
      // The parity edge completes the word but is not shifted in
      word      = sh_q;
      perr_word = ^{sh_q, SI};
      sh_d      = (SE && !done) ? shifted : sh_q;
`else
      word      = shifted;
      perr_word = 1'b0;
      sh_d      = SE ? shifted : sh_q;
`endif
   end

   always_comb begin
      load   = done && ((state_q == EMPTY) || QR);
      drop   = done && (state_q == FULL) && !QR;
      q_d    = load ? word : q_q;
      perr_d = load ? perr_word : perr_q;
      ovf_d  = ovf_q | drop;
   end

   always_ff @(posedge CK) begin
      if (CD) begin
         state_q <= EMPTY;
         sh_q    <= '0;
         cnt_q   <= '0;
         q_q     <= '0;
         ovf_q   <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         ovf_q   <= ovf_d;
         perr_q  <= perr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         EMPTY: if (done) state_d = FULL;
         FULL:  if (!done && QR) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      QV   = (state_q == FULL);
      Q    = q_q;
      OVF  = ovf_q;
      PERR = perr_q;
   end

endmodule

// File: tb/tb_sipo_capture.sv
// Directed bench for sipo_capture: MSB-first and LSB-first instances
// share one serial stream; expected words are hand-computed constants.
module tb_sipo_capture;

`ifdef SIPO_PARITY_EN
   localparam int NB = 9;
`else
   localparam int NB = 8;
`endif

   logic       CK, CD, SI, SE, QR;
   logic [7:0] Q_m, Q_l;
   logic       QV_m, QV_l, OVF_m, OVF_l, PERR_m, PERR_l;

   int checks = 0;
   int errors = 0;

   sipo_capture #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
      .CK(CK), .CD(CD), .SI(SI), .SE(SE), .QR(QR),
      .Q(Q_m), .QV(QV_m), .OVF(OVF_m), .PERR(PERR_m)
   );

   sipo_capture #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
      .CK(CK), .CD(CD), .SI(SI), .SE(SE), .QR(QR),
      .Q(Q_l), .QV(QV_l), .OVF(OVF_l), .PERR(PERR_l)
   );

   initial begin
      CK = 1'b0;
      forever #5 CK = ~CK;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CK);
      #1;
   endtask

   task automatic bit_in(input logic b);
      SE = 1'b1;
      SI = b;
      tick();
      SE = 1'b0;
   endtask

   task automatic do_reset();
      CD = 1'b1;
      tick();
      CD = 1'b0;
   endtask

   // Sends w first-bit-at-w[7]; QR takes qr_fin on the completing edge
   task automatic send_word(input logic [7:0] w, input logic qr_fin,
                            input logic pflip);
      for (int i = 7; i >= 0; i--) begin
         if (i == 0 && NB == 8) QR = qr_fin;
         bit_in(w[i]);
      end
      if (NB == 9) begin
         QR = qr_fin;
         bit_in((^w) ^ pflip);
      end
   endtask

   typedef struct {
      logic [7:0] w;
      logic [7:0] exp_m;
      logic [7:0] exp_l;
   } vec_t;

   vec_t tbl[5];
   int   pulses;
   logic [7:0] stream [3];
   logic b;

   initial begin
      tbl[0] = '{8'hA5, 8'hA5, 8'hA5};
      tbl[1] = '{8'hC0, 8'hC0, 8'h03};
      tbl[2] = '{8'h12, 8'h12, 8'h48};
      tbl[3] = '{8'hF0, 8'hF0, 8'h0F};
      tbl[4] = '{8'h3C, 8'h3C, 8'h3C};

      CD = 1'b0; SI = 1'b0; SE = 1'b0; QR = 1'b0;
      tick();
      SE = 1'b1; SI = 1'b1; QR = 1'b1;
      do_reset();
      SE = 1'b0;
      chk("rst_q", Q_m, 8'h00);
      chk("rst_qv", QV_m, 1'b0);
      chk("rst_ovf", OVF_m, 1'b0);
      chk("rst_perr", PERR_m, 1'b0);

      QR = 1'b1;
      for (int k = 0; k < 5; k++) begin
         for (int i = 7; i >= 1; i--) bit_in(tbl[k].w[i]);
         if (NB == 9) bit_in(tbl[k].w[0]);
         chk($sformatf("tbl%0d_qv_early", k), QV_m, 1'b0);
         bit_in(NB == 9 ? ^tbl[k].w : tbl[k].w[0]);
         chk($sformatf("tbl%0d_qv", k), QV_m, 1'b1);
         chk($sformatf("tbl%0d_q_msb", k), Q_m, tbl[k].exp_m);
         chk($sformatf("tbl%0d_q_lsb", k), Q_l, tbl[k].exp_l);
         chk($sformatf("tbl%0d_ovf", k), OVF_m, 1'b0);
         chk($sformatf("tbl%0d_perr", k), PERR_m, 1'b0);
         tick();
         chk($sformatf("tbl%0d_qv_drop", k), QV_m, 1'b0);
         chk($sformatf("tbl%0d_q_hold", k), Q_m, tbl[k].exp_m);
      end

      // Completion while FULL with QR=1 replaces the word with no bubble
      do_reset();
      QR = 1'b0;
      send_word(8'h11, 1'b0, 1'b0);
      chk("nb_first_q", Q_m, 8'h11);
      send_word(8'h22, 1'b1, 1'b0);
      chk("nb_second_q", Q_m, 8'h22);
      chk("nb_second_qv", QV_m, 1'b1);
      chk("nb_ovf", OVF_m, 1'b0);
      tick();
      chk("nb_qv_drop", QV_m, 1'b0);

      // Overflow: second word dropped while stalled
      QR = 1'b0;
      send_word(8'h3C, 1'b0, 1'b0);
      chk("ovf_first_q", Q_m, 8'h3C);
      chk("ovf_first_flag", OVF_m, 1'b0);
      send_word(8'hC3, 1'b0, 1'b0);
      chk("ovf_q_kept", Q_m, 8'h3C);
      chk("ovf_qv", QV_m, 1'b1);
      chk("ovf_flag", OVF_m, 1'b1);
      QR = 1'b1;
      tick();
      chk("ovf_qv_drop", QV_m, 1'b0);
      QR = 1'b0;
      tick();
      tick();
      chk("ovf_sticky", OVF_m, 1'b1);
      do_reset();
      chk("ovf_cleared", OVF_m, 1'b0);

      // Continuous stream, three words, one QV pulse each
      stream[0] = 8'h96; stream[1] = 8'h3C; stream[2] = 8'hE1;
      QR = 1'b1;
      pulses = 0;
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < NB; i++) begin
            b = (i < 8) ? stream[k][7-i] : ^stream[k];
            SE = 1'b1;
            SI = b;
            tick();
            if (QV_m) pulses++;
            if (i == NB - 1) begin
               chk($sformatf("strm%0d_qv", k), QV_m, 1'b1);
               chk($sformatf("strm%0d_q", k), Q_m, stream[k]);
            end
         end
      end
      SE = 1'b0;
      tick();
      if (QV_m) pulses++;
      chk("strm_pulses", pulses, 3);
      chk("strm_ovf", OVF_m, 1'b0);

      // Partial word discarded by reset
      for (int i = 0; i < 4; i++) bit_in(1'b1);
      SE = 1'b1;
      SI = 1'b1;
      do_reset();
      SE = 1'b0;
      chk("part_rst_qv", QV_m, 1'b0);
      chk("part_rst_q", Q_m, 8'h00);
      send_word(8'h5A, 1'b1, 1'b0);
      chk("part_q_msb", Q_m, 8'h5A);
      chk("part_q_lsb", Q_l, 8'h5A);
      chk("part_qv", QV_m, 1'b1);
      tick();

      // SE gaps freeze the shifter
      stream[0] = 8'h81;
      for (int i = 0; i < NB; i++) begin
         b = (i < 8) ? stream[0][7-i] : ^stream[0];
         bit_in(b);
         if (i < NB - 1) begin
            SI = ~b;
            tick();
            SI = b;
            tick();
            chk($sformatf("gap%0d_qv", i), QV_m, 1'b0);
         end
      end
      chk("gap_q_msb", Q_m, 8'h81);
      chk("gap_q_lsb", Q_l, 8'h81);
      chk("gap_qv", QV_m, 1'b1);
      tick();

`ifdef SIPO_PARITY_EN
      send_word(8'h07, 1'b1, 1'b0);
      chk("par_ok_q", Q_m, 8'h07);
      chk("par_ok_perr", PERR_m, 1'b0);
      send_word(8'h07, 1'b1, 1'b1);
      chk("par_bad_q", Q_m, 8'h07);
      chk("par_bad_perr", PERR_m, 1'b1);
      QR = 1'b0;
      tick();
      chk("par_bad_hold", PERR_m, 1'b1);
`else
      send_word(8'h07, 1'b1, 1'b0);
      chk("nopar_q", Q_m, 8'h07);
      chk("nopar_perr", PERR_m, 1'b0);
      chk("nopar_perr_lsb", PERR_l, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
